// File: rtl/ml_kem_pkg.sv
// ml_kem_pkg: shared ML-KEM constants and coefficient-reader state encoding
//   Q, N            : modulus and polynomial length
//   WIDTH, WORDW    : coefficient and BRAM word widths
//   reader_state_e  : IDLE -> RUN -> DONE
package ml_kem_pkg;
   localparam int WIDTH                = 16;
   localparam int WORDW                = 32;
   localparam int WIDTH_ADDR_BUTTERFLY = 8;
   localparam int N                    = 2 ** WIDTH_ADDR_BUTTERFLY;
   localparam int Q                    = 3329;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} reader_state_e;
endpackage

// File: rtl/ntt_skid_fifo2.sv
// ntt_skid_fifo2: 2-entry registered FIFO, head always in e0
//   clk, rst_n : clock, async active-low reset
//   push, din  : write an entry (caller never pushes into a full FIFO without popping)
//   pop, dout  : remove the head / head entry
//   count      : occupancy 0..2
module ntt_skid_fifo2 #(
   parameter int DW = 17
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic [1:0]    count
);
   logic [DW-1:0] e0, e1;
   assign dout = e0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e0    <= '0;
         e1    <= '0;
         count <= '0;
      end else begin
         if (push && (count == 2'd0 || (count == 2'd1 && pop))) e0 <= din;
         else if (pop) e0 <= e1;
         if (push && ((count == 2'd1 && !pop) || count == 2'd2)) e1 <= din;
         count <= count + 2'(push) - 2'(pop);
      end
   end
endmodule

// File: rtl/ntt_coeff_reader.sv
// ntt_coeff_reader: drains the 256-entry NTT result BRAM in order onto a valid/ready stream
//   clk, rst_n        : clock, async active-low reset
//   start             : begin a drain (ignored unless idle)
//   ren, raddr, rdata : BRAM read port, data one cycle after ren
//   m_data, m_valid, m_ready, m_last : output stream, m_last on index 255
//   busy, done        : drain in progress / one-cycle completion pulse
//   err_range         : sticky flag for any word with coef >= Q or non-zero upper bits
module ntt_coeff_reader
   import ml_kem_pkg::*;
(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   output logic                            ren,
   output logic [WIDTH_ADDR_BUTTERFLY-1:0] raddr,
   input  logic [WORDW-1:0]                rdata,
   output logic [WIDTH-1:0]                m_data,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic                            m_last,
   output logic                            busy,
   output logic                            done,
   output logic                            err_range
);
   localparam int PW = WIDTH_ADDR_BUTTERFLY + 1;
   localparam logic [PW-1:0] PTR_END = PW'(N);
   localparam logic [PW-1:0] PTR_LAST = PW'(N - 1);
   reader_state_e state, state_nxt;
   logic [PW-1:0] rd_ptr;
   logic inflight, inflight_last, pop, head_last, bad;
   logic [1:0] count;
   logic [2:0] occ;
   logic [WIDTH-1:0] head_data;
   // occupancy the buffer will have after this cycle's pop, counting the read in flight
   assign pop       = m_valid & m_ready;
   assign occ       = 3'(count) + 3'(inflight) - 3'(pop);
   assign ren       = state == RUN && rd_ptr < PTR_END && occ < 3'd2;
   assign raddr     = rd_ptr[WIDTH_ADDR_BUTTERFLY-1:0];
   assign m_valid   = count != 2'd0;
   assign m_data    = m_valid ? head_data : '0;
   assign m_last    = m_valid & head_last;
   assign busy      = state == RUN;
   assign done      = state == DONE;
   assign bad       = rdata[WIDTH-1:0] >= WIDTH'(Q) || rdata[WORDW-1:WIDTH] != '0;
   // the last-beat tag travels with the data so m_last needs no separate beat counter
   ntt_skid_fifo2 #(.DW(WIDTH + 1)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (inflight),
      .pop   (pop),
      .din   ({inflight_last, rdata[WIDTH-1:0]}),
      .dout  ({head_last, head_data}),
      .count (count)
   );
   always_comb begin
      state_nxt = state;
      state_nxt = state == IDLE ? (start ? RUN : IDLE) :
                  state == RUN  ? (pop && head_last ? DONE : RUN) : IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         rd_ptr        <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         err_range     <= 1'b0;
      end else begin
         state         <= state_nxt;
         inflight      <= ren;
         inflight_last <= ren && rd_ptr == PTR_LAST;
         if (state == IDLE && start) begin
            rd_ptr    <= '0;
            err_range <= 1'b0;
         end else begin
            if (ren) rd_ptr <= rd_ptr + 1'b1;
            if (inflight && bad) err_range <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_ntt_coeff_reader.sv
// tb_ntt_coeff_reader: directed scenario bench for ntt_coeff_reader with a BRAM model
module tb_ntt_coeff_reader;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, m_ready = 1'b0;
   logic ren, m_valid, m_last, busy, done, err_range;
   logic [7:0] raddr;
   logic [31:0] rdata;
   logic [15:0] m_data;
   logic [31:0] mem [256];
   logic [15:0] got [256];
   int n_checks = 0, n_fail = 0;
   int got_n, first_valid, last_viol, hold_viol, ren_viol, addr_viol, busy_viol;
   int done_cnt, done_c, last_c, err_n, err_drop, stall_n, timeout;
   logic err_c0, ren_c0;

   always #5 clk = ~clk;
   always @(posedge clk) if (ren) rdata <= mem[raddr];

   ntt_coeff_reader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ren(ren), .raddr(raddr), .rdata(rdata),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .busy(busy), .done(done), .err_range(err_range)
   );

   task automatic fill_mem();
      for (int i = 0; i < 256; i++) mem[i] = 32'((i * 13) % 3329);
   endtask

   function automatic int data_errs();
      int e = 0;
      for (int i = 0; i < 256; i++) if (got[i] !== mem[i][15:0]) e++;
      return e;
   endfunction

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // mode 0: ready high, 1: ready 1,0,0,1 pattern, 2: start re-pulsed at beat 100,
   // 3: ready low for 5 cycles while the last beat is pending
   task automatic run_drain(input int mode);
      int occ, issued;
      logic pstall, pl, pop;
      logic [15:0] pd;
      occ = 0; issued = 0; pstall = 0; pl = 0; pd = 0;
      got_n = 0; first_valid = -1; last_viol = 0; hold_viol = 0; ren_viol = 0; addr_viol = 0;
      busy_viol = 0; done_cnt = 0; done_c = -1; last_c = -1; err_n = -1; err_drop = 0;
      stall_n = 0; timeout = 1;
      for (int i = 0; i < 256; i++) got[i] = 16'hxxxx;
      pulse_start();
      for (int c = 0; c < 3000; c++) begin
         if (mode == 3 && m_valid && m_last && stall_n < 5) begin
            m_ready = 1'b0;
            stall_n++;
         end else m_ready = mode == 1 ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
         if (mode == 2) start = got_n == 100;
         #1;
         pop = m_valid && m_ready;
         if (c == 0) begin
            err_c0 = err_range;
            ren_c0 = ren && raddr == 8'd0;
         end
         if (m_valid && first_valid < 0) first_valid = c;
         if (pstall && (!m_valid || m_data !== pd || m_last !== pl)) hold_viol++;
         if (ren && occ - int'(pop) >= 2) ren_viol++;
         if (ren && int'(raddr) != issued) addr_viol++;
         if (err_range && err_n < 0) err_n = got_n;
         if (!err_range && err_n >= 0) err_drop++;
         if ((!busy && !done && done_cnt == 0) || (busy && done)) busy_viol++;
         if (done) begin
            done_cnt++;
            done_c = c;
         end
         if (pop) begin
            if (got_n < 256) got[got_n] = m_data;
            if (m_last != (got_n == 255)) last_viol++;
            last_c = c;
            got_n++;
         end
         pstall = m_valid && !m_ready;
         pd = m_data;
         pl = m_last;
         occ = occ + int'(ren) - int'(pop);
         issued = issued + int'(ren);
         if (done_cnt > 0 && c > done_c) begin
            timeout = 0;
            break;
         end
         @(negedge clk);
      end
      start = 1'b0;
      m_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({ren, raddr, m_valid, m_data, m_last, busy, done, err_range} !== 30'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 0", {ren, raddr, m_valid, m_data, m_last, busy, done, err_range});
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({ren, m_valid, busy, done} !== 4'd0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got %b expected 0000", {ren, m_valid, busy, done});
      end
   endtask

   task automatic test_full_drain();
      fill_mem();
      run_drain(0);
      n_checks++; if (timeout !== 0) begin n_fail++; $display("FAIL full_timeout: got %0d expected 0", timeout); end
      n_checks++; if (ren_c0 !== 1'b1) begin n_fail++; $display("FAIL full_first_read: got %b expected 1", ren_c0); end
      n_checks++; if (first_valid !== 2) begin n_fail++; $display("FAIL full_latency: got %0d expected 2", first_valid); end
      n_checks++; if (got_n !== 256) begin n_fail++; $display("FAIL full_beats: got %0d expected 256", got_n); end
      n_checks++; if (data_errs() !== 0) begin n_fail++; $display("FAIL full_data: got %0d bad beats expected 0", data_errs()); end
      n_checks++; if (last_c !== first_valid + 255) begin n_fail++; $display("FAIL full_back_to_back: got last at %0d expected %0d", last_c, first_valid + 255); end
      n_checks++; if (last_viol !== 0) begin n_fail++; $display("FAIL full_last: got %0d bad m_last expected 0", last_viol); end
      n_checks++; if (done_cnt !== 1 || done_c !== last_c + 1) begin n_fail++; $display("FAIL full_done: got %0d pulses at %0d expected 1 at %0d", done_cnt, done_c, last_c + 1); end
      n_checks++; if (busy_viol !== 0) begin n_fail++; $display("FAIL full_busy: got %0d bad cycles expected 0", busy_viol); end
      n_checks++; if (addr_viol !== 0) begin n_fail++; $display("FAIL full_raddr: got %0d bad addresses expected 0", addr_viol); end
      n_checks++; if (err_range !== 1'b0) begin n_fail++; $display("FAIL full_err: got %b expected 0", err_range); end
   endtask

   task automatic test_backpressure();
      fill_mem();
      run_drain(1);
      n_checks++; if (got_n !== 256) begin n_fail++; $display("FAIL bp_beats: got %0d expected 256", got_n); end
      n_checks++; if (data_errs() !== 0) begin n_fail++; $display("FAIL bp_data: got %0d bad beats expected 0", data_errs()); end
      n_checks++; if (hold_viol !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable stalls expected 0", hold_viol); end
      n_checks++; if (ren_viol !== 0) begin n_fail++; $display("FAIL bp_ren_full: got %0d overfill reads expected 0", ren_viol); end
      n_checks++; if (addr_viol !== 0) begin n_fail++; $display("FAIL bp_raddr: got %0d bad addresses expected 0", addr_viol); end
      n_checks++; if (last_viol !== 0) begin n_fail++; $display("FAIL bp_last: got %0d bad m_last expected 0", last_viol); end
      n_checks++; if (done_cnt !== 1 || done_c !== last_c + 1) begin n_fail++; $display("FAIL bp_done: got %0d pulses at %0d expected 1 at %0d", done_cnt, done_c, last_c + 1); end
   endtask

   task automatic test_range_error();
      fill_mem();
      mem[17]  = 32'd3329;
      mem[200] = 32'h0001_0005;
      run_drain(0);
      n_checks++; if (err_n !== 17) begin n_fail++; $display("FAIL range_rise: got rise after %0d beats expected 17", err_n); end
      n_checks++; if (err_drop !== 0) begin n_fail++; $display("FAIL range_sticky: got %0d low cycles expected 0", err_drop); end
      n_checks++; if (got_n !== 256 || data_errs() !== 0) begin n_fail++; $display("FAIL range_data: got %0d beats %0d bad expected 256 0", got_n, data_errs()); end
      n_checks++; if (err_range !== 1'b1) begin n_fail++; $display("FAIL range_after_done: got %b expected 1", err_range); end
      fill_mem();
      run_drain(0);
      n_checks++; if (err_c0 !== 1'b0) begin n_fail++; $display("FAIL range_clear_on_start: got %b expected 0", err_c0); end
      n_checks++; if (err_range !== 1'b0) begin n_fail++; $display("FAIL range_clean_drain: got %b expected 0", err_range); end
   endtask

   task automatic test_start_during_run();
      fill_mem();
      run_drain(2);
      n_checks++; if (got_n !== 256 || data_errs() !== 0) begin n_fail++; $display("FAIL restart_data: got %0d beats %0d bad expected 256 0", got_n, data_errs()); end
      n_checks++; if (done_cnt !== 1 || done_c !== last_c + 1) begin n_fail++; $display("FAIL restart_done: got %0d pulses at %0d expected 1 at %0d", done_cnt, done_c, last_c + 1); end
      n_checks++; if (last_c !== first_valid + 255) begin n_fail++; $display("FAIL restart_continuity: got last at %0d expected %0d", last_c, first_valid + 255); end
   endtask

   task automatic test_reset_mid_drain();
      int cnt = 0;
      fill_mem();
      pulse_start();
      m_ready = 1'b1;
      for (int c = 0; c < 400 && cnt < 50; c++) begin
         #1;
         if (m_valid) cnt++;
         if (cnt < 50) @(negedge clk);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++; if (cnt !== 50) begin n_fail++; $display("FAIL rst_mid_reach: got %0d beats expected 50", cnt); end
      n_checks++; if ({m_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_valid_busy: got %b expected 00", {m_valid, busy}); end
      n_checks++;
      if ({ren, raddr, m_data, m_last, done, err_range} !== 28'd0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: got %h expected 0", {ren, raddr, m_data, m_last, done, err_range});
      end
      m_ready = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      run_drain(0);
      n_checks++; if (first_valid !== 2) begin n_fail++; $display("FAIL rst_mid_relatency: got %0d expected 2", first_valid); end
      n_checks++; if (got_n !== 256 || data_errs() !== 0) begin n_fail++; $display("FAIL rst_mid_redrain: got %0d beats %0d bad expected 256 0", got_n, data_errs()); end
   endtask

   task automatic test_end_stall();
      fill_mem();
      run_drain(3);
      n_checks++; if (stall_n !== 5) begin n_fail++; $display("FAIL end_stall_cycles: got %0d expected 5", stall_n); end
      n_checks++; if (hold_viol !== 0) begin n_fail++; $display("FAIL end_stall_hold: got %0d unstable stalls expected 0", hold_viol); end
      n_checks++; if (busy_viol !== 0) begin n_fail++; $display("FAIL end_stall_busy: got %0d bad cycles expected 0", busy_viol); end
      n_checks++; if (last_c !== first_valid + 260) begin n_fail++; $display("FAIL end_stall_accept: got last at %0d expected %0d", last_c, first_valid + 260); end
      n_checks++; if (done_cnt !== 1 || done_c !== last_c + 1) begin n_fail++; $display("FAIL end_stall_done: got %0d pulses at %0d expected 1 at %0d", done_cnt, done_c, last_c + 1); end
      n_checks++; if (got_n !== 256 || last_viol !== 0) begin n_fail++; $display("FAIL end_stall_beats: got %0d beats %0d bad m_last expected 256 0", got_n, last_viol); end
   endtask

   initial begin
      test_reset();
      test_full_drain();
      test_backpressure();
      test_range_error();
      test_start_during_run();
      test_reset_mid_drain();
      test_end_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ntt_coeff_reader.md
Name: ntt_coeff_reader

Overview:
- Read-side companion of the NTT/INTT core's result BRAM: once the core raises done_store, this block drains the 256-entry coefficient memory in index order 0..255.
- Streams coefficients out on a valid/ready interface with m_last on the final beat, absorbing the 1-cycle BRAM read latency and downstream backpressure with a 2-entry buffer.
- Range-checks every word against q = 3329 and flags any out-of-range or non-zero upper bits.
- Sits between the NTT top's BRAM read port and the next ML-KEM stage (compress/encode or poly-multiply).

Parameters:
- WIDTH, 16, coefficient width on the output stream.
- WORDW, 32, BRAM word width; coefficient is rdata[WIDTH-1:0].
- WIDTH_ADDR_BUTTERFLY, 8, BRAM address width (N = 2**WIDTH_ADDR_BUTTERFLY = 256).
- Q, 3329, ML-KEM modulus used for the range check.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a drain; normally wired to the core's done_store.
- ren  out  1  BRAM read enable.
- raddr  out  WIDTH_ADDR_BUTTERFLY  BRAM read address.
- rdata  in  WORDW  BRAM read data, valid the cycle after ren.
- m_data  out  WIDTH  coefficient out.
- m_valid  out  1  m_data valid.
- m_ready  in  1  sink accepts; a beat transfers when m_valid & m_ready.
- m_last  out  1  high with beat index 255.
- busy  out  1  drain in progress.
- done  out  1  one-cycle pulse after the last beat transfers.
- err_range  out  1  sticky: some word had coef >= Q or rdata[WORDW-1:WIDTH] != 0.

Behaviour:
- Reset (async, any time including mid-drain): state IDLE; read pointer, in-flight flag, FIFO count and beat counter cleared.
  - Outputs at reset: ren=0, raddr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, err_range=0.
  - After reset, any in-flight BRAM read is discarded.
- FSM IDLE -> RUN -> DONE -> IDLE.
  - IDLE: start=1 at an edge moves to RUN, clears rd_ptr, beat count and err_range. busy=1 from that edge.
  - RUN: read issue rule is ren = (rd_ptr < N) && (fifo_count + inflight - pop) < 2, where pop = m_valid & m_ready. raddr = rd_ptr; rd_ptr increments on each issue.
  - RUN: inflight is set the cycle after an issue. Returned rdata is pushed into the FIFO at the end of that cycle; a push and a pop in the same cycle leave the count unchanged.
  - RUN: m_valid = FIFO non-empty. m_data is the FIFO head, held stable while m_valid & !m_ready.
  - RUN: m_last = m_valid && head index == N-1. When the beat with m_last transfers, go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- start while in RUN or DONE is ignored.
- Latency: start edge E0 -> ren=1, raddr=0 in the cycle after E0 -> m_valid=1 after E2. With m_ready held high, one beat per cycle, 256 consecutive beats; done pulses in the cycle after the m_last transfer.
- The buffer never overflows: at most 2 entries are occupied or in flight. With m_ready=0, ren stops after the FIFO plus in-flight reach 2.
- Range check on push: err if rdata[WIDTH-1:0] >= Q or the upper bits are non-zero. err_range is set sticky and cleared only by reset or the next accepted start. Data is forwarded unchanged regardless of err.
- Address wrap: rd_ptr is WIDTH_ADDR_BUTTERFLY+1 bits wide, so the value N terminates issue; raddr never wraps to 0 within a drain.

Decomposition:
- Shared package ml_kem_pkg holds:
  - constants Q=3329, N=256, WIDTH, WORDW, WIDTH_ADDR_BUTTERFLY;
  - reader state encoding localparams (IDLE, RUN, DONE).
- One natural sub-module: ntt_skid_fifo2, a 2-entry registered FIFO carrying {last, data} with push/pop/count. It is reusable for a future loader on the write side.

Test Plan:
- Full drain, m_ready=1: preload mem[i]=i*13 mod 3329, pulse start.
  - m_valid first high 2 cycles after start; 256 consecutive beats with m_data=i*13 mod 3329.
  - m_last only on beat 255; done pulses once 1 cycle later; err_range=0.
- Backpressure: m_ready toggles 1,0,0,1 repeatedly.
  - Output sequence is still 0..255 in order with no drops or duplicates; m_data stays stable while stalled.
  - ren never asserts while 2 entries are held; done follows the last transfer.
- Range error: mem[17]=3329, mem[200]=0x0001_0005.
  - err_range rises after word 17 is pushed and stays high; all 256 beats still delivered; the next start clears err_range.
- start during RUN: pulse start at beat 100 -> no restart, beat count continues, a single done pulse.
- Reset mid-drain: assert rst_n=0 at beat 50.
  - All outputs go to their reset values immediately (m_valid=0, busy=0).
  - A fresh start afterwards delivers beats 0..255 from index 0.
- Stall at the end: m_ready=0 while the m_last beat is pending for 5 cycles.
  - m_last and m_valid stay held; done only follows the accepting cycle; busy stays 1 throughout.
